frame_capture_buffer: RTL
=========================

# frame_capture_buffer

Parametrised successor to the single-word SPRAM test write in the camera top level. It decimates a camera pixel stream, buffers kept pixels in a small FIFO, and arbitrates one single-port SPRAM between capture writes and display reads. It sits between the `camera_read` output (already in the `clk` domain) and the VGA pattern/readout path, and drives one `SB_SPRAM256KA` directly.

## Interface
Parameters:
- PIX_W, 16, pixel width (RGB565); must be ≤ 16
- IN_W, 640, active pixels per input line
- IN_H, 480, active lines per input frame
- DECIM, 4, decimation factor in x and y; power of 2, ≥ 1
- ADDR_W, 14, SPRAM word address width
- FIFO_DEPTH, 8, write FIFO entries; power of 2, ≥ 2

Ports:
- clk  in  1  system clock (25 MHz)
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of an input frame
- pix_valid  in  1  pix_data valid this cycle
- pix_data  in  PIX_W  input pixel, raster order
- rd_req  in  1  display read request
- rd_addr  in  ADDR_W  display read address
- rd_valid  out  1  rd_data valid
- rd_data  out  PIX_W  read pixel
- ram_addr  out  ADDR_W  to SPRAM ADDRESS, registered
- ram_wdata  out  16  to SPRAM DATAIN, registered, zero-extended from PIX_W
- ram_wren  out  1  to SPRAM WREN, registered
- ram_rdata  in  16  from SPRAM DATAOUT
- overflow  out  1  sticky: a kept pixel was dropped this frame
- frame_count  out  8  completed frame_start pulses, wraps 255→0

## Operation
- Counters x (0..IN_W-1), y (0..IN_H-1), wr_ptr (ADDR_W bits) track the input raster.
- Each pix_valid: pixel kept iff x%DECIM==0 and y%DECIM==0 and y<IN_H. x increments; on x==IN_W-1 x→0 and y increments, saturating at IN_H.
- Kept pixel with wr_ptr < 2^ADDR_W pushes {wr_ptr, pix_data} into FIFO, and wr_ptr increments. When wr_ptr has reached capacity, pixels are clipped: no push, no overflow.
- Kept pixel with FIFO full: dropped, wr_ptr still increments (image geometry preserved), overflow←1.
- frame_start: x, y, wr_ptr←0; overflow←0; frame_count+1. FIFO is not flushed. pix_valid in the same cycle is processed as pixel (0,0) of the new frame.
- Arbiter, one SPRAM access per cycle, read priority:
  - rd_req=1: ram_addr←rd_addr, ram_wren←0.
  - else FIFO non-empty: pop; ram_addr←entry addr, ram_wdata←entry data, ram_wren←1.
  - else ram_wren←0, ram_addr holds.
- FIFO push and pop in the same cycle are both allowed, including when full (pop frees the slot first).

## Timing
- Reset values: ram_addr=0, ram_wdata=0, ram_wren=0, rd_valid=0, rd_data=0, overflow=0, frame_count=0; FIFO empty; x=y=wr_ptr=0. Reset mid-frame discards FIFO contents.
- Read latency is 2: rd_req sampled at edge N → ram_addr at N; SPRAM data at N+1; rd_valid=1 with rd_data=ram_rdata[PIX_W-1:0] registered at edge N+2. rd_valid=0 otherwise and rd_data holds.
- Write latency: a kept pixel at edge N enters the FIFO at N. The earliest ram_wren is at edge N+1, and only if rd_req is low at that edge.
- Back-to-back rd_req every cycle starves writes. Sustained capture throughput therefore requires rd_req duty < 1 − 1/DECIM².
- overflow and frame_count update on the same edge that samples frame_start or the dropped pixel.

## Test plan
- Reset, then a 16×8 frame with IN_W=16, IN_H=8, DECIM=2, pix_data=index, and no reads: 32 writes at addresses 0..31 with data 0,2,4..14,32,34..; overflow=0; frame_count=1.
- After the first test, read address 5 with one rd_req: rd_valid pulses exactly 2 cycles later with rd_data=10.
- rd_req held high continuously during a DECIM=1 frame with FIFO_DEPTH=4: 4 writes buffered, 5th kept pixel dropped, overflow=1. After rd_req drops, 4 writes drain. The next frame_start clears overflow.
- ADDR_W=4 with a 64-kept-pixel frame: exactly 16 writes (addresses 0..15), overflow=0.
- frame_start and pix_valid in the same cycle mid-frame: that pixel is written to address 0, and pending FIFO entries from the old frame still complete at their original addresses.
- rst_n pulsed low mid-frame with a non-empty FIFO: all outputs return to reset values immediately, and no further ram_wren occurs until new pixels arrive.

Source files
------------

// File: rtl/frame_capture_buffer.sv
// frame_capture_buffer: decimate a pixel stream, queue kept pixels, share one SPRAM between capture writes and display reads
module frame_capture_buffer #(
    parameter int PIX_W      = 16,
    parameter int IN_W       = 640,
    parameter int IN_H       = 480,
    parameter int DECIM      = 4,
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [15:0]       ram_rdata,
    output logic              overflow,
    output logic [7:0]        frame_count
);
    localparam int XW = $clog2(IN_W + 1);
    localparam int YW = $clog2(IN_H + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [XW-1:0] X_MASK = XW'(DECIM - 1);
    localparam logic [YW-1:0] Y_MASK = YW'(DECIM - 1);
    localparam logic [XW-1:0] X_LAST = XW'(IN_W - 1);
    localparam logic [YW-1:0] Y_END  = YW'(IN_H);

    logic [XW-1:0]           x, x_cur, x_next;
    logic [YW-1:0]           y, y_cur, y_next;
    logic [ADDR_W:0]         wr_ptr, ptr_cur;
    logic                    keep, room, push, pop, drop;
    logic [FW:0]             head, tail;
    logic                    fifo_full, fifo_empty;
    logic [ADDR_W+PIX_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_W+PIX_W-1:0] head_entry;
    logic                    rd_p1, rd_p2;

    // A frame_start pixel is treated as pixel (0,0) of the new frame, so decode from restarted counters
    always_comb begin
        x_cur      = frame_start ? '0 : x;
        y_cur      = frame_start ? '0 : y;
        ptr_cur    = frame_start ? '0 : wr_ptr;
        x_next     = (x_cur == X_LAST) ? '0 : x_cur + 1'b1;
        y_next     = (x_cur == X_LAST && y_cur != Y_END) ? y_cur + 1'b1 : y_cur;
        keep       = pix_valid && ((x_cur & X_MASK) == '0) && ((y_cur & Y_MASK) == '0) && (y_cur < Y_END);
        room       = !ptr_cur[ADDR_W];
        fifo_empty = (head == tail);
        fifo_full  = ((head ^ tail) == {1'b1, {FW{1'b0}}});
        pop        = !rd_req && !fifo_empty;
        push       = keep && room && (!fifo_full || pop);
        drop       = keep && room && fifo_full && !pop;
        head_entry = fifo_mem[head[FW-1:0]];
    end

    // Raster position and write pointer; dropped pixels still advance the pointer to keep geometry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            wr_ptr <= '0;
        end else begin
            x      <= pix_valid ? x_next : x_cur;
            y      <= pix_valid ? y_next : y_cur;
            wr_ptr <= (keep && room) ? ptr_cur + 1'b1 : ptr_cur;
        end
    end

    // FIFO storage holds {address, pixel}; contents are don't-care once pointers reset
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[tail[FW-1:0]] <= {ptr_cur[ADDR_W-1:0], pix_data};
    end

    // FIFO pointers; extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
        end
    end

    // SPRAM arbiter: display reads win, otherwise drain one queued write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
        end else begin
            ram_wren <= pop;
            if (rd_req) begin
                ram_addr <= rd_addr;
            end else if (pop) begin
                ram_addr  <= head_entry[ADDR_W+PIX_W-1:PIX_W];
                ram_wdata <= 16'(head_entry[PIX_W-1:0]);
            end
        end
    end

    // Read return pipeline: address registered, SPRAM access, then capture of DATAOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_p1    <= 1'b0;
            rd_p2    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_p1    <= rd_req;
            rd_p2    <= rd_p1;
            rd_valid <= rd_p2;
            if (rd_p2)
                rd_data <= ram_rdata[PIX_W-1:0];
        end
    end

    // Per-frame status: overflow sticky within a frame, frame counter wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            overflow <= (frame_start ? 1'b0 : overflow) | drop;
            if (frame_start)
                frame_count <= frame_count + 8'd1;
        end
    end
endmodule
